dmc_decode_seq: RTL and testbench

Frame sequencer for one DMC decode lane. It drives the decoder's `enable`, `clk_or_data` and `receive_line_rst_n` inputs, and counts decoder FIFO pops to step a frame through three phases: acquisition, a sync field of fixed pop count, and a data field of fixed pop count. It then flushes until the decoder reports `early_receive_done`. One instance sits beside each decoder instance (lane A, lane B) in the decode control wrapper, in the 98 MHz `clk_i` domain.

---
 rtl/dmc_decode_seq.sv | 202 ++++++++++++++++++++
 tb/tb_dmc_decode_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmc_decode_seq.sv
// dmc_decode_seq: frame sequencer for one DMC decode lane (enable, clk_or_data, line reset).
// Optional no-pop watchdog is built when DMC_SEQ_WATCHDOG_EN is defined.
module dmc_decode_seq #(
  parameter int CNT_W         = 10,
  parameter int TMO_W         = 16,
  parameter int RST_PULSE_CYC = 4
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_sync_pops,
  input  logic [CNT_W-1:0] cfg_data_pops,
  input  logic [TMO_W-1:0] cfg_timeout,
  input  logic             dec_pop_en,
  input  logic             dec_early_done,
  output logic             dec_enable,
  output logic             dec_clk_or_data,
  output logic             dec_line_rst_n,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] pop_count
);
  // state   | meaning
  // S_IDLE  | decoder disabled, waiting for start
  // S_ARM   | line reset pulse before enabling the decoder
  // S_ACQ   | decoder enabled, waiting for the first (uncounted) pop
  // S_SYNC  | counting sync-field pops
  // S_DATA  | counting data-field pops, clk_or_data low
  // S_FLUSH | waiting for early_receive_done
  // S_DONE  | frame_done pulse, back to idle
  // S_ERR   | frame_err pulse plus line reset pulse, back to idle
  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_ACQ, S_SYNC, S_DATA, S_FLUSH, S_DONE, S_ERR
  } state_e;

  localparam int            PW       = (RST_PULSE_CYC > 1) ? $clog2(RST_PULSE_CYC) : 1;
  localparam logic [PW-1:0] PULSE_LD = PW'(RST_PULSE_CYC - 1);

  state_e           state_q;
  logic [PW-1:0]    pulse_q;
  logic             dec_enable_q, dec_clk_or_data_q, dec_line_rst_n_q;
  logic             busy_q, frame_done_q, frame_err_q;
  logic [2:0]       err_code_q;
  logic [CNT_W-1:0] pop_count_q;
  logic [CNT_W-1:0] pop_inc;
  logic             live;
  logic             tmo_hit;
  logic             err_go;
  logic [2:0]       err_val;

  assign pop_inc = pop_count_q + 1'b1;
  assign live    = state_q inside {S_ARM, S_ACQ, S_SYNC, S_DATA, S_FLUSH};

`ifdef DMC_SEQ_WATCHDOG_EN
  logic [TMO_W-1:0] wdog_q;
  logic             wd_run;

  assign wd_run  = state_q inside {S_ACQ, S_SYNC, S_DATA, S_FLUSH};
  assign tmo_hit = wd_run && (cfg_timeout != '0) && (wdog_q + 1'b1 == cfg_timeout);

  // Cleared on every pop and on every exit from the watched states.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      wdog_q <= '0;
    end else if (!wd_run || err_go || dec_pop_en || (cfg_timeout == '0) ||
                 (state_q == S_FLUSH && dec_early_done)) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^cfg_timeout;
  assign tmo_hit    = 1'b0;
`endif

  // Error priority: abort, then early done in a counted phase, then timeout (a pop saves it).
  always_comb begin
    err_go  = 1'b0;
    err_val = 3'd0;
    if (live) begin
      if (abort) begin
        err_go  = 1'b1;
        err_val = 3'd4;
      end else if ((state_q == S_SYNC || state_q == S_DATA) && dec_early_done) begin
        err_go  = 1'b1;
        err_val = 3'd3;
      end else if (tmo_hit && !dec_pop_en && !(state_q == S_FLUSH && dec_early_done)) begin
        err_go  = 1'b1;
        err_val = (state_q == S_ACQ) ? 3'd1 : 3'd2;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q           <= S_IDLE;
      pulse_q           <= '0;
      dec_enable_q      <= 1'b0;
      dec_clk_or_data_q <= 1'b1;
      dec_line_rst_n_q  <= 1'b1;
      busy_q            <= 1'b0;
      frame_done_q      <= 1'b0;
      frame_err_q       <= 1'b0;
      err_code_q        <= '0;
      pop_count_q       <= '0;
    end else begin
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (err_go) begin
        state_q           <= S_ERR;
        err_code_q        <= err_val;
        frame_err_q       <= 1'b1;
        dec_enable_q      <= 1'b0;
        dec_clk_or_data_q <= 1'b1;
        dec_line_rst_n_q  <= 1'b0;
        pulse_q           <= PULSE_LD;
        pop_count_q       <= '0;
      end else begin
        case (state_q)
          S_IDLE: if (start) begin
            state_q          <= S_ARM;
            busy_q           <= 1'b1;
            dec_line_rst_n_q <= 1'b0;
            pulse_q          <= PULSE_LD;
            err_code_q       <= '0;
          end
          S_ARM: if (pulse_q == '0) begin
            state_q          <= S_ACQ;
            dec_line_rst_n_q <= 1'b1;
            dec_enable_q     <= 1'b1;
          end else begin
            pulse_q <= pulse_q - 1'b1;
          end
          S_ACQ: if (dec_pop_en) begin
            if (cfg_sync_pops != '0) begin
              state_q <= S_SYNC;
            end else if (cfg_data_pops != '0) begin
              state_q           <= S_DATA;
              dec_clk_or_data_q <= 1'b0;
            end else begin
              state_q <= S_FLUSH;
            end
          end
          S_SYNC: if (dec_pop_en) begin
            if (pop_inc == cfg_sync_pops) begin
              pop_count_q <= '0;
              if (cfg_data_pops != '0) begin
                state_q           <= S_DATA;
                dec_clk_or_data_q <= 1'b0;
              end else begin
                state_q <= S_FLUSH;
              end
            end else begin
              pop_count_q <= pop_inc;
            end
          end
          S_DATA: if (dec_pop_en) begin
            if (pop_inc == cfg_data_pops) begin
              state_q           <= S_FLUSH;
              dec_clk_or_data_q <= 1'b1;
              pop_count_q       <= '0;
            end else begin
              pop_count_q <= pop_inc;
            end
          end
          S_FLUSH: if (dec_early_done) begin
            state_q      <= S_DONE;
            dec_enable_q <= 1'b0;
            frame_done_q <= 1'b1;
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          S_ERR: if (pulse_q == '0) begin
            state_q          <= S_IDLE;
            busy_q           <= 1'b0;
            dec_line_rst_n_q <= 1'b1;
          end else begin
            pulse_q <= pulse_q - 1'b1;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign dec_enable      = dec_enable_q;
  assign dec_clk_or_data = dec_clk_or_data_q;
  assign dec_line_rst_n  = dec_line_rst_n_q;
  assign busy            = busy_q;
  assign frame_done      = frame_done_q;
  assign frame_err       = frame_err_q;
  assign err_code        = err_code_q;
  assign pop_count       = pop_count_q;

endmodule

// File: tb/tb_dmc_decode_seq.sv
// Self-checking bench for dmc_decode_seq: hand-derived vector tables, corner sequences,
// and randomized traffic against a phase/remaining-pops reference model.
module tb_dmc_decode_seq;
  localparam int CNT_W = 10;
  localparam int TMO_W = 16;
  localparam int RPC   = 4;

  localparam int P_IDLE = 0, P_ARM = 1, P_ACQ = 2, P_SYNC = 3;
  localparam int P_DATA = 4, P_FLUSH = 5, P_DONE = 6, P_ERR = 7;

  logic             clk_i = 1'b0;
  logic             reset;
  logic             start, abort, dec_pop_en, dec_early_done;
  logic [CNT_W-1:0] cfg_sync_pops, cfg_data_pops;
  logic [TMO_W-1:0] cfg_timeout;
  logic             dec_enable, dec_clk_or_data, dec_line_rst_n;
  logic             busy, frame_done, frame_err;
  logic [2:0]       err_code;
  logic [CNT_W-1:0] pop_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model: current phase, pulse cycles left, pops still needed, idle cycles
  int m_ph, m_left, m_need, m_cnt, m_wd, m_code;
  bit m_done, m_err;

  typedef struct {
    bit st, ab, pop, ed;
    bit en, cod, rstn, bsy, dn, er;
    int cnt;
  } vec_t;
  vec_t tbl[$];

  dmc_decode_seq #(.CNT_W(CNT_W), .TMO_W(TMO_W), .RST_PULSE_CYC(RPC)) dut (
    .clk_i(clk_i), .reset(reset), .start(start), .abort(abort),
    .cfg_sync_pops(cfg_sync_pops), .cfg_data_pops(cfg_data_pops), .cfg_timeout(cfg_timeout),
    .dec_pop_en(dec_pop_en), .dec_early_done(dec_early_done),
    .dec_enable(dec_enable), .dec_clk_or_data(dec_clk_or_data), .dec_line_rst_n(dec_line_rst_n),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err),
    .err_code(err_code), .pop_count(pop_count)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", nm, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = P_IDLE; m_left = 0; m_need = 0; m_cnt = 0; m_wd = 0; m_code = 0;
    m_done = 0; m_err = 0;
  endtask

  task automatic fail_to(input int code);
    m_ph = P_ERR; m_left = RPC; m_code = code; m_err = 1;
  endtask

  task automatic model_step();
    int ph0;
    ph0 = m_ph;
    m_done = 0;
    m_err  = 0;
    case (m_ph)
      P_IDLE: if (start) begin m_ph = P_ARM; m_left = RPC; m_code = 0; end
      P_DONE: m_ph = P_IDLE;
      P_ERR: begin m_left--; if (m_left == 0) m_ph = P_IDLE; end
      default: begin
        if (abort) fail_to(4);
        else if (m_ph == P_ARM) begin m_left--; if (m_left == 0) m_ph = P_ACQ; end
        else if ((m_ph == P_SYNC || m_ph == P_DATA) && dec_early_done) fail_to(3);
        else if (m_ph == P_FLUSH && dec_early_done) begin m_ph = P_DONE; m_done = 1; end
        else if (dec_pop_en) begin
          m_wd = 0;
          if (m_ph == P_ACQ) begin
            m_ph = P_SYNC; m_need = int'(cfg_sync_pops);
            if (m_need == 0) begin
              m_ph = P_DATA; m_need = int'(cfg_data_pops);
              if (m_need == 0) m_ph = P_FLUSH;
            end
          end else if (m_ph == P_SYNC || m_ph == P_DATA) begin
            m_need--; m_cnt++;
            if (m_need == 0) begin
              if (m_ph == P_SYNC && cfg_data_pops != 0) begin
                m_ph = P_DATA; m_need = int'(cfg_data_pops);
              end else m_ph = P_FLUSH;
            end
          end
        end else begin
          m_wd++;
`ifdef DMC_SEQ_WATCHDOG_EN
          if (cfg_timeout != 0 && m_wd >= int'(cfg_timeout)) fail_to(m_ph == P_ACQ ? 1 : 2);
`endif
        end
      end
    endcase
    if (m_ph != ph0) begin m_cnt = 0; m_wd = 0; end
  endtask

  task automatic tick();
    @(posedge clk_i);
    if (reset) model_reset(); else model_step();
    #1;
    cyc++;
  endtask

  task automatic check_model(input string tag);
    bit run;
    run = (m_ph == P_ACQ || m_ph == P_SYNC || m_ph == P_DATA || m_ph == P_FLUSH);
    chk({tag, ".dec_enable"}, dec_enable, run);
    chk({tag, ".dec_clk_or_data"}, dec_clk_or_data, m_ph != P_DATA);
    chk({tag, ".dec_line_rst_n"}, dec_line_rst_n, !(m_ph == P_ARM || m_ph == P_ERR));
    chk({tag, ".busy"}, busy, m_ph != P_IDLE);
    chk({tag, ".frame_done"}, frame_done, m_done);
    chk({tag, ".frame_err"}, frame_err, m_err);
    chk({tag, ".err_code"}, err_code, m_code);
    chk({tag, ".pop_count"}, pop_count, m_cnt);
  endtask

  task automatic step(input bit st, input bit ab, input bit pop, input bit ed, input string tag);
    start = st; abort = ab; dec_pop_en = pop; dec_early_done = ed;
    tick();
    start = 0; abort = 0; dec_pop_en = 0; dec_early_done = 0;
    check_model(tag);
  endtask

  task automatic add(input bit st, input bit ab, input bit pop, input bit ed,
                     input bit en, input bit cod, input bit rstn, input bit bsy,
                     input bit dn, input bit er, input int cnt);
    vec_t v;
    v.st = st; v.ab = ab; v.pop = pop; v.ed = ed;
    v.en = en; v.cod = cod; v.rstn = rstn; v.bsy = bsy; v.dn = dn; v.er = er; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  // start, 4-cycle line reset, ACQ, first pop; with sync=3 continues through 3 sync pops into DATA
  task automatic add_head(input bit with_sync);
    add(1,0,0,0, 0,1,0,1,0,0,0);
    repeat (RPC-1) add(0,0,0,0, 0,1,0,1,0,0,0);
    add(0,0,0,0, 1,1,1,1,0,0,0);
    if (with_sync) begin
      add(0,0,1,0, 1,1,1,1,0,0,0);
      for (int k = 1; k <= 2; k++) add(0,0,1,0, 1,1,1,1,0,0,k);
      add(0,0,1,0, 1,0,1,1,0,0,0);
    end
  endtask

  task automatic build_nominal();
    add_head(1);
    for (int k = 1; k <= 7; k++) add(0,0,1,0, 1,0,1,1,0,0,k);
    add(0,0,1,0, 1,1,1,1,0,0,0);
    add(0,0,0,0, 1,1,1,1,0,0,0);
    add(0,0,0,1, 0,1,1,1,1,0,0);
    add(0,0,0,0, 0,1,1,0,0,0,0);
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      start = tbl[i].st; abort = tbl[i].ab; dec_pop_en = tbl[i].pop; dec_early_done = tbl[i].ed;
      tick();
      chk($sformatf("%s[%0d].dec_enable", tag, i), dec_enable, tbl[i].en);
      chk($sformatf("%s[%0d].dec_clk_or_data", tag, i), dec_clk_or_data, tbl[i].cod);
      chk($sformatf("%s[%0d].dec_line_rst_n", tag, i), dec_line_rst_n, tbl[i].rstn);
      chk($sformatf("%s[%0d].busy", tag, i), busy, tbl[i].bsy);
      chk($sformatf("%s[%0d].frame_done", tag, i), frame_done, tbl[i].dn);
      chk($sformatf("%s[%0d].frame_err", tag, i), frame_err, tbl[i].er);
      chk($sformatf("%s[%0d].pop_count", tag, i), pop_count, tbl[i].cnt);
    end
    start = 0; abort = 0; dec_pop_en = 0; dec_early_done = 0;
    tbl.delete();
  endtask

  initial begin
    reset = 1; start = 0; abort = 0; dec_pop_en = 0; dec_early_done = 0;
    cfg_sync_pops = 10'd3; cfg_data_pops = 10'd8; cfg_timeout = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst.dec_enable", dec_enable, 0);
    chk("rst.dec_clk_or_data", dec_clk_or_data, 1);
    chk("rst.dec_line_rst_n", dec_line_rst_n, 1);
    chk("rst.busy", busy, 0);
    chk("rst.frame_done", frame_done, 0);
    chk("rst.frame_err", frame_err, 0);
    chk("rst.err_code", err_code, 0);
    chk("rst.pop_count", pop_count, 0);
    @(negedge clk_i);
    reset = 0;

    build_nominal();
    run_table("nominal");
    chk("nominal.err_code", err_code, 0);

    // FIFO runs dry after 5 of 8 data pops
    add_head(1);
    for (int k = 1; k <= 5; k++) add(0,0,1,0, 1,0,1,1,0,0,k);
    add(0,0,0,1, 0,1,0,1,0,1,0);
    repeat (RPC-1) add(0,0,0,0, 0,1,0,1,0,0,0);
    add(0,0,0,0, 0,1,1,0,0,0,0);
    run_table("dry");
    chk("dry.err_code", err_code, 3);
    step(0,0,0,0, "dry.hold");

    cfg_sync_pops = '0; cfg_data_pops = '0;
    add_head(0);
    add(0,0,1,0, 1,1,1,1,0,0,0);
    add(0,0,0,0, 1,1,1,1,0,0,0);
    add(0,0,0,1, 0,1,1,1,1,0,0);
    add(0,0,0,0, 0,1,1,0,0,0,0);
    run_table("skip");

    // no pops in ACQ with a 20-cycle watchdog
    cfg_sync_pops = 10'd3; cfg_data_pops = 10'd8; cfg_timeout = 16'd20;
    step(1,0,0,0, "wd");
    repeat (RPC) step(0,0,0,0, "wd");
    chk("wd.in_acq", dec_enable, 1);
    repeat (19) step(0,0,0,0, "wd");
    chk("wd.before_limit", frame_err, 0);
    step(0,0,0,0, "wd.limit");
`ifdef DMC_SEQ_WATCHDOG_EN
    chk("wd.err_pulse", frame_err, 1);
    chk("wd.code", err_code, 1);
`else
    chk("wd.still_acq", dec_enable, 1);
    chk("wd.no_err", frame_err, 0);
    step(0,1,0,0, "wd.abort");
    chk("wd.abort_code", err_code, 4);
`endif
    repeat (RPC) step(0,0,0,0, "wd.tail");
    chk("wd.idle", busy, 0);

    // abort on the same DATA cycle the watchdog would expire
    step(1,0,0,0, "race");
    chk("race.code_cleared", err_code, 0);
    repeat (RPC) step(0,0,0,0, "race");
    repeat (4) step(0,0,1,0, "race");
    chk("race.in_data", dec_clk_or_data, 0);
    repeat (2) step(0,0,1,0, "race");
    repeat (19) step(0,0,0,0, "race");
    step(0,1,0,0, "race.abort");
    chk("race.code", err_code, 4);
    chk("race.err_pulse", frame_err, 1);
    repeat (RPC) step(0,0,0,0, "race.tail");

    // asynchronous reset in the middle of DATA, then a clean frame
    cfg_timeout = '0;
    step(1,0,0,0, "mid");
    repeat (RPC) step(0,0,0,0, "mid");
    repeat (7) step(0,0,1,0, "mid");
    chk("mid.pre_busy", busy, 1);
    reset = 1;
    #2;
    chk("mid.async.dec_enable", dec_enable, 0);
    chk("mid.async.busy", busy, 0);
    chk("mid.async.dec_line_rst_n", dec_line_rst_n, 1);
    chk("mid.async.dec_clk_or_data", dec_clk_or_data, 1);
    chk("mid.async.pop_count", pop_count, 0);
    model_reset();
    @(negedge clk_i);
    reset = 0;
    build_nominal();
    run_table("post_reset");
    chk("post_reset.err_code", err_code, 0);

    for (int c = 0; c < 6000; c++) begin
      if (m_ph == P_IDLE && $urandom_range(0, 3) == 0) begin
        cfg_sync_pops = CNT_W'($urandom_range(0, 4));
        cfg_data_pops = CNT_W'($urandom_range(0, 6));
        cfg_timeout   = ($urandom_range(0, 3) == 0) ? '0 : TMO_W'($urandom_range(1, 10));
      end
      start          = ($urandom_range(0, 3) == 0);
      abort          = ($urandom_range(0, 99) == 0);
      dec_pop_en     = ($urandom_range(0, 9) < 4);
      dec_early_done = (m_ph == P_FLUSH) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
      tick();
      check_model("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
